decoder_stage_controller: RTL

- Global sequencer for the Z-ancilla processing_unit array: drives global_stage to every PE and steps the union-find decode through measurement load, grow/merge iterations, peeling and result hand-off.
- Watches OR-reduced PE busy/odd vectors to decide when merge has converged and whether another grow round is needed.
- Sits between the measurement front-end (start handshake) and the correction read-out (result handshake).

---
 rtl/decoder_stage_controller_pkg.sv | 19 +
 rtl/decoder_stage_controller_or_reduce_registered.sv | 19 +
 rtl/decoder_stage_controller.sv | 129 ++++++++++++
 3 files changed

// File: rtl/decoder_stage_controller_pkg.sv
// decoder_stage_controller_pkg: stage encoding shared by the controller and the PE array
package decoder_stage_controller_pkg;
   localparam int STAGE_WIDTH = 3;
   localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
   localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
   localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
   localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
   localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;
   localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd5;
   localparam int PHASE_CNT_WIDTH = 16;
   typedef enum logic [STAGE_WIDTH-1:0] {
      ST_IDLE                = STAGE_IDLE,
      ST_MEASUREMENT_LOADING = STAGE_MEASUREMENT_LOADING,
      ST_GROW                = STAGE_GROW,
      ST_MERGE               = STAGE_MERGE,
      ST_PEELING             = STAGE_PEELING,
      ST_RESULT_VALID        = STAGE_RESULT_VALID
   } stage_e;
endpackage

// File: rtl/decoder_stage_controller_or_reduce_registered.sv
// or_reduce_registered: one-cycle registered OR-reduction of a PE status vector
module or_reduce_registered
   import decoder_stage_controller_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_vec,
   output logic             o_any
);
   logic r_any;
   // register the reduction so PE status never reaches the sequencer combinationally
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_any <= 1'b0;
      else          r_any <= |i_vec;
   end
   assign o_any = r_any;
endmodule

// File: rtl/decoder_stage_controller.sv
// decoder_stage_controller: global stage sequencer for the union-find PE array
module decoder_stage_controller
   import decoder_stage_controller_pkg::*;
#(
   parameter int PE_COUNT       = 64,
   parameter int GROW_CYCLES    = 1,
   parameter int MERGE_SETTLE   = 3,
   parameter int MAX_ITERATIONS = 16,
   parameter int PEEL_CYCLES    = 8,
   parameter int ITER_WIDTH     = 5,
   parameter int CYCLE_WIDTH    = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start_valid,
   output logic                   o_start_ready,
   input  logic [PE_COUNT-1:0]    i_pe_busy,
   input  logic [PE_COUNT-1:0]    i_pe_odd,
   output logic [STAGE_WIDTH-1:0] o_global_stage,
   output logic                   o_result_valid,
   input  logic                   i_result_ready,
   output logic                   o_result_error,
   output logic [ITER_WIDTH-1:0]  o_iteration_count,
   output logic [CYCLE_WIDTH-1:0] o_cycle_count
);
   logic                       w_busy_any;
   logic                       w_odd_any;
   logic [ITER_WIDTH-1:0]      w_iter_next;
   stage_e                     r_state;
   logic [PHASE_CNT_WIDTH-1:0] r_cnt;
   logic [ITER_WIDTH-1:0]      r_iter;
   logic [CYCLE_WIDTH-1:0]     r_cycles;
   logic                       r_error;
   logic                       r_start_ready;
   logic                       r_result_valid;

   or_reduce_registered #(.WIDTH(PE_COUNT)) u_busy_or (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vec(i_pe_busy), .o_any(w_busy_any)
   );
   or_reduce_registered #(.WIDTH(PE_COUNT)) u_odd_or (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vec(i_pe_odd), .o_any(w_odd_any)
   );

   assign w_iter_next = r_iter + ITER_WIDTH'(1);

   // stage sequencing; r_cnt times the fixed-length phases and the merge settle window
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_iter         <= '0;
         r_cycles       <= '0;
         r_error        <= 1'b0;
         r_start_ready  <= 1'b1;
         r_result_valid <= 1'b0;
      end else begin
         if (r_state != ST_IDLE && r_state != ST_RESULT_VALID && r_cycles != '1)
            r_cycles <= r_cycles + CYCLE_WIDTH'(1);
         unique case (r_state)
            ST_IDLE: begin
               if (i_start_valid) begin
                  r_state       <= ST_MEASUREMENT_LOADING;
                  r_iter        <= '0;
                  r_cycles      <= '0;
                  r_error       <= 1'b0;
                  r_start_ready <= 1'b0;
               end
            end
            ST_MEASUREMENT_LOADING: begin
               r_state <= ST_GROW;
               r_cnt   <= '0;
            end
            ST_GROW: begin
               if (r_cnt == PHASE_CNT_WIDTH'(GROW_CYCLES - 1)) begin
                  r_state <= ST_MERGE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + PHASE_CNT_WIDTH'(1);
               end
            end
            ST_MERGE: begin
               if (r_cnt < PHASE_CNT_WIDTH'(MERGE_SETTLE - 1)) begin
                  r_cnt <= r_cnt + PHASE_CNT_WIDTH'(1);
               end else if (!w_busy_any) begin
                  r_cnt <= '0;
                  if (!w_odd_any) begin
                     r_state <= ST_PEELING;
                  end else begin
                     r_iter <= w_iter_next;
                     if (w_iter_next == ITER_WIDTH'(MAX_ITERATIONS)) begin
                        r_error <= 1'b1;
                        r_state <= ST_PEELING;
                     end else begin
                        r_state <= ST_GROW;
                     end
                  end
               end
            end
            ST_PEELING: begin
               if (r_cnt == PHASE_CNT_WIDTH'(PEEL_CYCLES - 1)) begin
                  r_state        <= ST_RESULT_VALID;
                  r_result_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + PHASE_CNT_WIDTH'(1);
               end
            end
            ST_RESULT_VALID: begin
               if (i_result_ready) begin
                  r_state        <= ST_IDLE;
                  r_result_valid <= 1'b0;
                  r_start_ready  <= 1'b1;
               end
            end
            default: begin
               r_state        <= ST_IDLE;
               r_start_ready  <= 1'b1;
               r_result_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_global_stage    = r_state;
   assign o_start_ready     = r_start_ready;
   assign o_result_valid    = r_result_valid;
   assign o_result_error    = r_error;
   assign o_iteration_count = r_iter;
   assign o_cycle_count     = r_cycles;
endmodule
